// File: rtl/divisor_unit.sv
// 32-bit signed restoring divider (MIPS div semantics), one quotient bit per clock.
// Optional macro DIV_ZERO_EXC_EN: a zero divisor skips the iteration and pulses div_zero with done.
module divisor_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        div_control,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] div_hi,
  output logic [31:0] div_lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [5:0] ITER_LAST = 6'd31;

  state_t      state;
  state_t      state_nxt;
  logic [5:0]  cnt;
  logic [31:0] mag_b;
  logic        sign_a;
  logic        sign_b;
  logic [31:0] rem;
  logic [31:0] quo;
  logic        dz_flag;

  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] trial;
  logic [31:0] rem_nxt;
  logic [31:0] quo_nxt;
  logic        start;
  logic        b_is_zero;

  // Two's-complement magnitude; 0x80000000 maps to itself, which is the correct
  // unsigned magnitude in 32 bits.
  assign abs_a     = a[31] ? (~a + 32'd1) : a;
  assign abs_b     = b[31] ? (~b + 32'd1) : b;
  assign start     = (state == IDLE) && div_control;
  assign b_is_zero = (b == 32'd0);

  // One restoring step: shift {rem,quo} left, try subtracting |b|. The
  // invariant rem < |b| keeps the shifted value below 2^32, so a 33-bit
  // difference is enough for its sign bit to be meaningful.
  always_comb begin
    trial   = {1'b0, rem[30:0], quo[31]} - {1'b0, mag_b};
    rem_nxt = {rem[30:0], quo[31]};
    quo_nxt = {quo[30:0], 1'b0};
    if (!trial[32]) begin
      rem_nxt    = trial[31:0];
      quo_nxt[0] = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (div_control) begin
`ifdef DIV_ZERO_EXC_EN
          state_nxt = b_is_zero ? DONE : ITER;
`else
          state_nxt = ITER;
`endif
        end
      end
      ITER:    if (cnt == ITER_LAST) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the working registers are reset along with the visible outputs; the
  // design is small and a fully known state after reset costs nothing here.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt     <= 6'd0;
      mag_b   <= 32'd0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      rem     <= 32'd0;
      quo     <= 32'd0;
      dz_flag <= 1'b0;
      div_hi  <= 32'd0;
      div_lo  <= 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          dz_flag <= 1'b0;
          if (start) begin
            mag_b  <= abs_b;
            sign_a <= a[31];
            sign_b <= b[31];
            rem    <= 32'd0;
            quo    <= abs_a;
            cnt    <= 6'd0;
`ifdef DIV_ZERO_EXC_EN
            dz_flag <= b_is_zero;
`endif
          end
        end
        ITER: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + 6'd1;
        end
        FIX: begin
          // Quotient truncates toward zero; remainder follows the dividend's sign.
          div_lo <= (sign_a ^ sign_b) ? (~quo + 32'd1) : quo;
          div_hi <= sign_a ? (~rem + 32'd1) : rem;
        end
        DONE: ;
        default: ;
      endcase
    end
  end

  assign busy = (state == ITER) || (state == FIX);
  assign done = (state == DONE);

`ifdef DIV_ZERO_EXC_EN
  assign div_zero = done && dz_flag;
`else
  assign div_zero = 1'b0;
`endif

  a_done_single: assert property (@(posedge clk) disable iff (!reset) done |=> !done);
  a_busy_done_excl: assert property (@(posedge clk) disable iff (!reset) !(busy && done));

endmodule

// File: tb/tb_divisor_unit.sv
// Directed, table-driven bench for divisor_unit; covers signs, overflow wrap,
// zero divisor (either build), ignored starts and mid-operation reset.
module tb_divisor_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        div_control;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] div_hi;
  logic [31:0] div_lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  divisor_unit dut (
    .clk         (clk),
    .reset       (reset),
    .div_control (div_control),
    .a           (a),
    .b           (b),
    .div_hi      (div_hi),
    .div_lo      (div_lo),
    .busy        (busy),
    .done        (done),
    .div_zero    (div_zero)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    string       name;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts an operation, waits (bounded) for done and checks latency, busy
  // span, results and the single-cycle done pulse.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_val,
                        input int exp_lat, input logic [31:0] exp_lo,
                        input logic [31:0] exp_hi, input logic exp_dz,
                        input string name);
    int cyc;
    int busy_cnt;
    bit seen;
    a = ta;
    b = tb_val;
    div_control = 1'b1;
    tick();
    div_control = 1'b0;
    a = $urandom;
    b = $urandom;
    cyc = 1;
    busy_cnt = 0;
    seen = 1'b0;
    while (!seen && cyc <= 60) begin
      if (done) seen = 1'b1;
      else begin
        if (busy) busy_cnt++;
        tick();
        cyc++;
      end
    end
    check({name, " latency"}, seen ? cyc : -1, exp_lat);
    check({name, " busy cycles"}, busy_cnt, exp_lat - 1);
    check({name, " div_lo"}, div_lo, exp_lo);
    check({name, " div_hi"}, div_hi, exp_hi);
    check({name, " div_zero"}, {31'd0, div_zero}, {31'd0, exp_dz});
    check({name, " busy in done"}, {31'd0, busy}, 32'd0);
    tick();
    check({name, " done width"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int dones;

    vecs[0]  = '{32'd100,      32'd7,        32'd14,       32'd2,        "100/7"};
    vecs[1]  = '{-32'sd100,    32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, "-100/7"};
    vecs[2]  = '{32'd100,      -32'sd7,      32'hFFFFFFF2, 32'd2,        "100/-7"};
    vecs[3]  = '{-32'sd100,    -32'sd7,      32'd14,       32'hFFFFFFFE, "-100/-7"};
    vecs[4]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        "min/-1"};
    vecs[5]  = '{32'd0,        32'd5,        32'd0,        32'd0,        "0/5"};
    vecs[6]  = '{32'd7,        32'd100,      32'd0,        32'd7,        "7/100"};
    vecs[7]  = '{32'h7FFFFFFF, 32'd1,        32'h7FFFFFFF, 32'd0,        "max/1"};
    vecs[8]  = '{32'h80000000, 32'd2,        32'hC0000000, 32'd0,        "min/2"};
    vecs[9]  = '{32'd1000000,  32'd3,        32'd333333,   32'd1,        "1e6/3"};
    vecs[10] = '{32'h7FFFFFFF, 32'h80000000, 32'd0,        32'h7FFFFFFF, "max/min"};

    reset = 1'b0;
    div_control = 1'b0;
    a = 32'd0;
    b = 32'd0;
    repeat (3) tick();
    check("reset div_lo", div_lo, 32'd0);
    check("reset div_hi", div_hi, 32'd0);
    check("reset flags", {29'd0, busy, done, div_zero}, 32'd0);
    reset = 1'b1;
    tick();

    // Each run ends in the IDLE cycle right after DONE, so consecutive vectors
    // also exercise back-to-back starts.
    for (int i = 0; i < 11; i++)
      run_op(vecs[i].a, vecs[i].b, 34, vecs[i].lo, vecs[i].hi, 1'b0, vecs[i].name);

    // Zero divisor; the previous result is 0 r 0x7FFFFFFF.
`ifdef DIV_ZERO_EXC_EN
    run_op(32'd5, 32'd0, 1, 32'd0, 32'h7FFFFFFF, 1'b1, "5/0");
    run_op(-32'sd5, 32'd0, 1, 32'd0, 32'h7FFFFFFF, 1'b1, "-5/0");
`else
    run_op(32'd5, 32'd0, 34, 32'hFFFFFFFF, 32'd5, 1'b0, "5/0");
    run_op(-32'sd5, 32'd0, 34, 32'd1, 32'hFFFFFFFB, 1'b0, "-5/0");
`endif

    // Start pulse at N+10 while busy must be ignored.
    a = 32'd9;
    b = 32'd2;
    div_control = 1'b1;
    tick();
    div_control = 1'b0;
    repeat (9) tick();
    a = 32'd1;
    b = 32'd1;
    div_control = 1'b1;
    tick();
    div_control = 1'b0;
    dones = 0;
    for (int c = 11; c < 34; c++) begin
      if (done) dones++;
      tick();
    end
    check("9/2 no early done", dones, 0);
    check("9/2 done at N+34", {31'd0, done}, 32'd1);
    check("9/2 div_lo", div_lo, 32'd4);
    check("9/2 div_hi", div_hi, 32'd1);

    // Start held during DONE is ignored; held into IDLE it starts.
    a = 32'd50;
    b = 32'd6;
    div_control = 1'b1;
    tick();
    check("start in DONE ignored", {30'd0, busy, done}, 32'd0);
    tick();
    div_control = 1'b0;
    check("start in IDLE taken", {31'd0, busy}, 32'd1);
    dones = 0;
    for (int c = 1; c < 60 && !done; c++) tick();
    check("50/6 div_lo", div_lo, 32'd8);
    check("50/6 div_hi", div_hi, 32'd2);
    tick();

    // Reset at M+5 aborts the operation.
    a = 32'd100;
    b = 32'd7;
    div_control = 1'b1;
    tick();
    div_control = 1'b0;
    repeat (4) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("abort div_lo", div_lo, 32'd0);
    check("abort div_hi", div_hi, 32'd0);
    check("abort flags", {29'd0, busy, done, div_zero}, 32'd0);
    dones = 0;
    repeat (40) begin
      if (done || busy) dones++;
      tick();
    end
    check("abort no done", dones, 0);
    run_op(32'd1000, 32'd10, 34, 32'd100, 32'd0, 1'b0, "after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
